// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter
//   Arbitrates one combinational instruction ROM between the CPU fetch port
//   and a debug read port. Byte addresses become ROM word indices and are
//   checked for alignment and range. Read data is registered, so every
//   response arrives exactly one cycle after its grant. Fetch normally wins.
//   A wait counter makes sure debug cannot be starved indefinitely.
//
// Ports
//   clk, resetn                       clock, synchronous active-low reset
//   fetch_req/fetch_addr              fetch request and byte address
//   fetch_gnt/fetch_stall             combinational grant / stall
//   fetch_rvalid/fetch_rdata/fetch_err  registered fetch response
//   dbg_req/dbg_addr                  debug request and byte address
//   dbg_gnt                           combinational debug grant
//   dbg_rvalid/dbg_rdata/dbg_err      registered debug response
//   rom_addr                          ROM word index (combinational)
//   rom_inst                          ROM data, combinational from rom_addr
//
// Response FSM states
//   state      | meaning
//   RESP_NONE  | no response presented this cycle
//   RESP_FETCH | fetch response valid this cycle
//   RESP_DBG   | debug response valid this cycle

module inst_rom_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 21,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_stall,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_err,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_FETCH = 2'd1,
    RESP_DBG   = 2'd2
  } resp_e;

  resp_e             resp_sel, resp_next;
  logic [CNT_W-1:0]  wait_cnt, wait_next;
  logic              force_dbg;
  logic [31:0]       gnt_addr;
  logic [ADDR_W-1:0] gnt_idx;
  logic              gnt_err;

  always_comb begin
    force_dbg   = 1'b0;
    fetch_gnt   = 1'b0;
    dbg_gnt     = 1'b0;
    fetch_stall = 1'b0;
    gnt_addr    = 32'h0;
    gnt_idx     = '0;
    gnt_err     = 1'b0;
    rom_addr    = '0;
    resp_next   = RESP_NONE;
    wait_next   = '0;

    // Debug overtakes fetch only once it has been refused MAX_WAIT times in a row.
    force_dbg   = dbg_req && (wait_cnt == WAIT_LIMIT);
    fetch_gnt   = fetch_req && !force_dbg;
    dbg_gnt     = dbg_req && !fetch_gnt;
    fetch_stall = fetch_req && !fetch_gnt;

    if (fetch_gnt)    gnt_addr = fetch_addr;
    else if (dbg_gnt) gnt_addr = dbg_addr;

    gnt_idx  = gnt_addr[ADDR_W+1:2];
    rom_addr = gnt_idx;
    gnt_err  = (gnt_addr[1:0] != 2'b00) ||
               (gnt_addr[31:ADDR_W+2] != '0) ||
               ({{(32-ADDR_W){1'b0}}, gnt_idx} >= DEPTH_W);

    if (fetch_gnt)    resp_next = RESP_FETCH;
    else if (dbg_gnt) resp_next = RESP_DBG;

    if (dbg_req && !dbg_gnt)
      wait_next = (wait_cnt == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_sel <= RESP_NONE;
      wait_cnt <= '0;
    end else begin
      resp_sel <= resp_next;
      wait_cnt <= wait_next;
    end
  end

  // Reset wins over a same-cycle grant, so that grant never produces a response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_rdata <= 32'h0;
      fetch_err   <= 1'b0;
      dbg_rdata   <= 32'h0;
      dbg_err     <= 1'b0;
    end else begin
      if (fetch_gnt) begin
        fetch_rdata <= gnt_err ? 32'h0 : rom_inst;
        fetch_err   <= gnt_err;
      end
      if (dbg_gnt) begin
        dbg_rdata <= gnt_err ? 32'h0 : rom_inst;
        dbg_err   <= gnt_err;
      end
    end
  end

  assign fetch_rvalid = (resp_sel == RESP_FETCH);
  assign dbg_rvalid   = (resp_sel == RESP_DBG);

endmodule
